// File: rtl/x_o_r.sv
// x_o_r: XOR of two bits, with a registered copy, running parity,
// a saturating mismatch counter and edge pulses on the registered result.
module x_o_r #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             en,
  input  logic             clr,
  output logic             Y,
  output logic             Y_q,
  output logic             par,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_sat,
  output logic             rise,
  output logic             fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             x;
  logic             yq_q, yq_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  assign x = A ^ B;

  // Next-state: en gates every sampled function; clr overrides parity and
  // count only, so Y_q and its edge pulses keep updating during a clear.
  always_comb begin
    yq_d   = yq_q;
    par_d  = par_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en) begin
      yq_d   = x;
      rise_d = x & ~yq_q;
      fall_d = ~x & yq_q;
    end
    if (clr) begin
      par_d = 1'b0;
      cnt_d = '0;
    end else if (en) begin
      par_d = par_q ^ x;
      if (x) begin
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  // State register; reset clears everything, including pulses, so a
  // reset-induced drop of Y_q never produces a fall pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      yq_q   <= 1'b0;
      par_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      yq_q   <= yq_d;
      par_q  <= par_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign Y       = x;
  assign Y_q     = yq_q;
  assign par     = par_q;
  assign cnt     = cnt_q;
  assign cnt_sat = (cnt_q == CNT_MAX);
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: tb/tb_x_o_r.sv
// Testbench for x_o_r: directed scenarios plus randomized traffic, all
// checked against a behavioural model kept as plain counts.
module tb_x_o_r;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0, A = 1'b0, B = 1'b0, en = 1'b0, clr = 1'b0;
  logic       Y, Y_q, par, cnt_sat, rise, fall;
  logic [7:0] cnt;
  logic       Y2, Y_q2, par2, cnt_sat2, rise2, fall2;
  logic [1:0] cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: Y_q value, count of ones sampled and mismatches since last clear.
  logic m_yq = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_ones = 0;
  int   m_mis  = 0;

  always #5 clk = clk_run & ~clk;

  x_o_r #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .en(en), .clr(clr),
    .Y(Y), .Y_q(Y_q), .par(par), .cnt(cnt), .cnt_sat(cnt_sat),
    .rise(rise), .fall(fall)
  );

  x_o_r #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .en(en), .clr(clr),
    .Y(Y2), .Y_q(Y_q2), .par(par2), .cnt(cnt2), .cnt_sat(cnt_sat2),
    .rise(rise2), .fall(fall2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_edge(input logic a, input logic b, input logic e,
                            input logic c, input logic r);
    logic prev;
    if (r) begin
      m_yq = 0; m_rise = 0; m_fall = 0; m_ones = 0; m_mis = 0;
    end else begin
      prev   = m_yq;
      m_rise = 0;
      m_fall = 0;
      if (e) begin
        m_yq   = a ^ b;
        m_rise = (prev == 0) && (m_yq == 1);
        m_fall = (prev == 1) && (m_yq == 0);
      end
      if (c) begin
        m_ones = 0; m_mis = 0;
      end else if (e && (a != b)) begin
        m_ones++; m_mis++;
      end
    end
  endtask

  task automatic check_all();
    int c8, c2;
    c8 = (m_mis > 255) ? 255 : m_mis;
    c2 = (m_mis > 3) ? 3 : m_mis;
    chk("Y_q", Y_q, m_yq);
    chk("par", par, m_ones % 2);
    chk("cnt", cnt, c8);
    chk("cnt_sat", cnt_sat, c8 == 255);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("Y_q_w2", Y_q2, m_yq);
    chk("par_w2", par2, m_ones % 2);
    chk("cnt_w2", cnt2, c2);
    chk("cnt_sat_w2", cnt_sat2, c2 == 3);
    chk("rise_w2", rise2, m_rise);
    chk("fall_w2", fall2, m_fall);
  endtask

  // One clock: apply inputs, check combinational Y, clock, check state.
  task automatic cycle(input logic a, input logic b, input logic e,
                       input logic c, input logic r);
    A = a; B = b; en = e; clr = c; rst = r;
    #1;
    chk("Y", Y, a ^ b);
    chk("Y_w2", Y2, a ^ b);
    @(posedge clk);
    model_edge(a, b, e, c, r);
    #1;
    check_all();
  endtask

  initial begin
    logic [1:0] ab_tab   [4] = '{2'b01, 2'b01, 2'b11, 2'b10};
    logic       yq_exp   [4] = '{1, 1, 0, 1};
    logic       par_exp  [4] = '{1, 0, 0, 1};
    int         cnt_exp  [4] = '{1, 2, 2, 3};
    logic       rise_exp [4] = '{1, 0, 0, 1};
    logic       fall_exp [4] = '{0, 0, 1, 0};
    int         c2_exp   [5] = '{1, 2, 3, 3, 3};
    logic       s2_exp   [5] = '{0, 0, 1, 1, 1};
    logic       yq_hold, par_hold;
    logic [7:0] cnt_hold;

    // Truth table with the clock stopped.
    for (int i = 0; i < 4; i++) begin
      A = i[1]; B = i[0];
      #100;
      chk("tt_Y", Y, i[1] ^ i[0]);
    end

    clk_run = 1'b1;
    @(posedge clk); #1;

    // Reset, with Y still tracking the operands.
    cycle(1, 0, 1, 0, 1);
    cycle(0, 1, 1, 0, 1);

    // Pattern 01,01,11,10 with explicit expected values.
    for (int i = 0; i < 4; i++) begin
      cycle(ab_tab[i][1], ab_tab[i][0], 1, 0, 0);
      chk("pat_yq", Y_q, yq_exp[i]);
      chk("pat_par", par, par_exp[i]);
      chk("pat_cnt", cnt, cnt_exp[i]);
      chk("pat_rise", rise, rise_exp[i]);
      chk("pat_fall", fall, fall_exp[i]);
    end

    // Saturation of the 2-bit counter.
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1, 0, 0);
      chk("sat_cnt2", cnt2, c2_exp[i]);
      chk("sat_flag2", cnt_sat2, s2_exp[i]);
    end

    // en=0 with toggling operands: everything holds, no pulses.
    yq_hold = Y_q; par_hold = par; cnt_hold = cnt;
    for (int i = 0; i < 4; i++) begin
      cycle(i[0], 0, 0, 0, 0);
      chk("hold_yq", Y_q, yq_hold);
      chk("hold_par", par, par_hold);
      chk("hold_cnt", cnt, cnt_hold);
      chk("hold_rf", {rise, fall}, 2'b00);
    end

    // Build cnt=3, par=1, Y_q=1, then reset, then clear with en.
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0);
    chk("pre_rst_cnt", cnt, 3);
    chk("pre_rst_par", par, 1);
    chk("pre_rst_yq", Y_q, 1);
    cycle(1, 0, 1, 0, 1);
    chk("rst_all", {Y_q, par, cnt, rise, fall}, 12'h0);
    for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 1, 0);
    chk("clr_par", par, 0);
    chk("clr_cnt", cnt, 0);
    chk("clr_yq", Y_q, 1);
    cycle(1, 0, 1, 1, 0);
    chk("clr_rise", rise, 0);

    // Long run without clear/reset to reach 8-bit saturation.
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 320; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) != 0, 0, 0);

    // Mixed random traffic including clear and reset.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/x_o_r.md
X_O_R -- requirements
Module: x_o_r

Interface
REQ-001 Parameter CNT_W, default 8: width of the mismatch counter; legal range 2..32.
REQ-002 Ports: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 A  input  1  first operand.
REQ-006 B  input  1  second operand.
REQ-007 en  input  1  sample enable for all registered functions.
REQ-008 clr  input  1  synchronous clear of accumulator and counter; registered output unaffected.
REQ-009 Y  output  1  combinational A XOR B.
REQ-010 Y_q  output  1  registered XOR result.
REQ-011 par  output  1  running XOR (parity) of every sampled result.
REQ-012 cnt  output  CNT_W  saturating count of sampled cycles where A differs from B.
REQ-013 cnt_sat  output  1  high while cnt equals all-ones.
REQ-014 rise  output  1  one-cycle pulse when Y_q goes 0->1.
REQ-015 fall  output  1  one-cycle pulse when Y_q goes 1->0.

Function
REQ-016 Y SHALL equal A XOR B at all times, with no clock or reset dependency: 00->0, 01->1, 10->1, 11->0.
REQ-017 On a rising clk edge with en=1, Y_q SHALL load A XOR B (latency one cycle); with en=0, Y_q SHALL hold.
REQ-018 On a rising edge with en=1, par SHALL update to par XOR (A XOR B); with en=0 it SHALL hold.
REQ-019 On a rising edge with en=1 and A!=B, cnt SHALL increment by 1 unless already all-ones, in which case it SHALL hold (no wrap).
REQ-020 cnt_sat SHALL be combinational from cnt: high iff cnt = 2^CNT_W-1.
REQ-021 rise SHALL be a registered pulse, high for exactly the cycle after Y_q changed 0->1; fall likewise for 1->0; rise and fall SHALL never both be high.
REQ-022 clr=1 (with rst=0) SHALL set par=0 and cnt=0 at the next edge, taking priority over en; Y_q, rise and fall SHALL update normally.
REQ-023 rst SHALL take priority over clr and en.
REQ-024 A and B SHALL be sampled only at rising clk edges for all registered outputs; there are no other state elements.

Reset
REQ-025 While rst=1 at a rising edge: Y_q=0, par=0, cnt=0, rise=0, fall=0; cnt_sat=0 follows from cnt.
REQ-026 Y SHALL continue to follow A XOR B during reset.
REQ-027 Reset asserted mid-operation SHALL discard all accumulated state at that edge, with no pulse generated by the reset-induced Y_q transition.
REQ-028 The first en=1 edge after reset release SHALL behave as from a clean zero state.

Verification
REQ-029 Truth table: A,B = 00,01,10,11, each held 100 ns -> Y = 0,1,1,0 with no clock running.
REQ-030 en=1, pattern AB = 01,01,11,10 on successive edges -> Y_q = 1,1,0,1; par = 1,0,0,1; cnt = 1,2,2,3; fall pulse after the third edge; rise pulse after the first and fourth edges.
REQ-031 CNT_W=2, en=1, A=1, B=0 for 5 edges -> cnt = 1,2,3,3,3; cnt_sat high from the third edge onward.
REQ-032 en=0 with A^B toggling for 4 edges -> Y_q, par, cnt unchanged; rise=fall=0; Y still tracks A^B.
REQ-033 cnt=3, par=1, Y_q=1, then rst=1 for one edge -> all registered outputs 0, no fall pulse; then clr=1 with en=1, A=1, B=0 -> par=0, cnt=0, Y_q=1, rise pulse next cycle.
